// File: rtl/fixed_mac_pkg.sv
// Shared widths, rounding modes and overflow modes for the fixed-point MAC family.
package fixed_mac_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } sat_mode_e;

    // Full-precision width of one signed A*B product.
    function automatic int prod_w(int wi1, int wf1, int wi2, int wf2);
        return wi1 + wf1 + wi2 + wf2;
    endfunction

    // Accumulator width: product, adder-tree growth, then packet-length guard bits.
    function automatic int acc_w(int pw, int lanes, int guard);
        return pw + $clog2(lanes) + guard;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational resize of a signed Q(.).(FI) value into Q(WIO).(WFO):
// shift or round, then saturate/wrap on overflow and handle underflow to zero.
module fixed_round_sat
    import fixed_mac_pkg::*;
#(
    parameter int ACC_W = 30,
    parameter int FI    = 13,
    parameter int WIO   = 15,
    parameter int WFO   = 30,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic               sat_en,
    input  logic               uf_sat,
    output logic [WIO+WFO-1:0] out_data,
    output logic               overflow,
    output logic               underflow
);
    localparam int OW = WIO + WFO;
    localparam int SH = (WFO >= FI) ? WFO - FI : 0;
    localparam int DR = (WFO >= FI) ? 0 : FI - WFO;
    // Wide enough for the shifted value, the rounding carry and the range limits.
    localparam int XW = ACC_W + SH + OW + 2;

    sat_mode_e             sat_mode;
    logic signed [XW-1:0]  acc_x;
    logic signed [XW-1:0]  q;
    logic signed [XW-1:0]  max_v;
    logic signed [XW-1:0]  min_v;
    logic                  ovf;

    assign sat_mode = sat_mode_e'(sat_en);
    assign acc_x    = XW'($signed(acc));
    assign max_v    = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    assign min_v    = ~max_v;

    if (DR == 0) begin : g_shl
        assign q = acc_x <<< SH;
    end else begin : g_shr
        logic signed [XW-1:0] fl;
        logic signed [XW-1:0] rb;
        assign fl = acc_x >>> DR;
        // Half-up: add the most significant dropped bit to the floored value.
        assign rb = (ROUND == ROUND_HALF_UP) ? $signed({{(XW-1){1'b0}}, acc_x[DR-1]}) : '0;
        assign q  = fl + rb;
    end

    // Range check happens after rounding so a rounding carry is caught.
    assign ovf = (q > max_v) || (q < min_v);

    // Select clamped, wrapped, underflow-substituted or plain result.
    always_comb begin
        out_data  = q[OW-1:0];
        overflow  = ovf;
        underflow = 1'b0;
        if (ovf) begin
            if (sat_mode == OVF_SAT)
                out_data = q[XW-1] ? min_v[OW-1:0] : max_v[OW-1:0];
        end else if (q == '0 && acc != '0) begin
            underflow = 1'b1;
            if (!uf_sat)
                out_data = '0;
            else if (acc[ACC_W-1])
                out_data = '1;
            else
                out_data = OW'(1);
        end
    end

endmodule

// File: rtl/fixed_mac_vec.sv
// Multi-lane signed fixed-point MAC with packet framing:
// lane products -> adder tree -> per-packet accumulator -> resize.
module fixed_mac_vec
    import fixed_mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WI1   = 4,
    parameter int WF1   = 8,
    parameter int WI2   = 3,
    parameter int WF2   = 5,
    parameter int WIO   = 15,
    parameter int WFO   = 30,
    parameter int GUARD = 8,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LANES*(WI1+WF1)-1:0]   a_data,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [LANES*(WI2+WF2)-1:0]   b_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic                         in_last,
    output logic [WIO+WFO-1:0]           out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         sat_en,
    input  logic                         uf_sat,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW  = WI1 + WF1;
    localparam int BW  = WI2 + WF2;
    localparam int PW  = prod_w(WI1, WF1, WI2, WF2);
    localparam int FP  = WF1 + WF2;
    localparam int LG  = $clog2(LANES);
    localparam int SW  = PW + LG;
    localparam int ACC = acc_w(PW, LANES, GUARD);
    localparam int NP  = 1 << LG;
    localparam int OW  = WIO + WFO;

    logic                          en;
    logic                          accept;
    logic [3:1]                    vld_pipe;
    logic [2:1]                    last_pipe;
    logic [LANES-1:0][PW-1:0]      mul;
    logic [LANES-1:0][PW-1:0]      prod;
    logic signed [SW-1:0]          node [0:2*NP-2];
    logic signed [SW-1:0]          sum2;
    logic signed [ACC-1:0]         acc;
    logic signed [ACC:0]           acc_nxt;
    logic                          first;
    logic                          sticky;
    logic                          wrap;
    logic [OW-1:0]                 rs_data;
    logic                          rs_ovf;
    logic                          rs_uf;

    // A held result freezes the whole pipe; A and B are accepted jointly.
    assign en      = !out_valid || out_ready;
    assign a_ready = en && b_valid;
    assign b_ready = en && a_valid;
    assign accept  = a_valid && b_valid && en;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        assign ax     = PW'($signed(a_data[l*AW +: AW]));
        assign bx     = PW'($signed(b_data[l*BW +: BW]));
        assign mul[l] = ax * bx;
    end

    // Binary adder tree padded to a power of two; node[0] is the root.
    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < LANES) begin : g_used
            assign node[NP-1+i] = SW'($signed(prod[i]));
        end else begin : g_pad
            assign node[NP-1+i] = '0;
        end
    end
    for (genvar i = 0; i < NP - 1; i++) begin : g_node
        assign node[i] = node[2*i+1] + node[2*i+2];
    end

    // The first beat of a packet starts from zero instead of the running sum.
    assign acc_nxt = (first ? '0 : {acc[ACC-1], acc}) + (ACC+1)'(sum2);
    assign wrap    = acc_nxt[ACC] ^ acc_nxt[ACC-1];

    // S1/S2: register lane products, then the tree sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[2:1]  <= '0;
            last_pipe      <= '0;
            prod           <= '0;
            sum2           <= '0;
        end else if (en) begin
            vld_pipe[1]    <= accept;
            last_pipe[1]   <= in_last;
            prod           <= mul;
            vld_pipe[2]    <= vld_pipe[1];
            last_pipe[2]   <= last_pipe[1];
            sum2           <= node[0];
        end
    end

    // S3: accumulate per packet and track accumulator wrap for the packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[3] <= 1'b0;
            acc         <= '0;
            sticky      <= 1'b0;
            first       <= 1'b1;
        end else if (en) begin
            vld_pipe[3] <= vld_pipe[2] && last_pipe[2];
            if (vld_pipe[2]) begin
                acc    <= acc_nxt[ACC-1:0];
                sticky <= (first ? 1'b0 : sticky) | wrap;
                first  <= last_pipe[2];
            end
        end
    end

    fixed_round_sat #(
        .ACC_W (ACC),
        .FI    (FP),
        .WIO   (WIO),
        .WFO   (WFO),
        .ROUND (ROUND)
    ) u_rs (
        .acc       (acc),
        .sat_en    (sat_en),
        .uf_sat    (uf_sat),
        .out_data  (rs_data),
        .overflow  (rs_ovf),
        .underflow (rs_uf)
    );

    // S4: capture the resized packet result; a wrapped packet always reports overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            out_valid <= vld_pipe[3];
            if (vld_pipe[3]) begin
                out_data  <= rs_data;
                overflow  <= rs_ovf | sticky;
                underflow <= rs_uf & ~sticky;
            end
        end
    end

endmodule

// File: tb/tb_fixed_mac_vec.sv
// Directed bench: default build plus Q4.4 and Q15.4 output builds share one stimulus stream.
module tb_fixed_mac_vec;
    localparam int LANES = 4;

    logic              clk;
    logic              reset;
    logic [LANES*12-1:0] a_data;
    logic [LANES*8-1:0]  b_data;
    logic              a_valid, b_valid, in_last, out_ready, sat_en, uf_sat;
    logic              a_ready, b_ready, a_ready1, b_ready1, a_ready2, b_ready2;
    logic [44:0]       od0;
    logic [7:0]        od1;
    logic [18:0]       od2;
    logic              ov0, ov1, ov2, ovf0, ovf1, ovf2, uf0, uf1, uf2;

    typedef struct {
        logic [63:0] d0, d1, d2;
        logic        o0, o1, o2, u0, u1, u2;
    } res_t;
    res_t q[$];
    res_t r;

    int total = 0;
    int bad   = 0;

    fixed_mac_vec u0 (.clk(clk), .reset(reset), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .in_last(in_last), .out_data(od0),
        .out_valid(ov0), .out_ready(out_ready), .sat_en(sat_en), .uf_sat(uf_sat),
        .overflow(ovf0), .underflow(uf0));
    fixed_mac_vec #(.WIO(4), .WFO(4)) u1 (.clk(clk), .reset(reset), .a_data(a_data), .a_valid(a_valid),
        .a_ready(a_ready1), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready1), .in_last(in_last),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .sat_en(sat_en), .uf_sat(uf_sat),
        .overflow(ovf1), .underflow(uf1));
    fixed_mac_vec #(.WFO(4)) u2 (.clk(clk), .reset(reset), .a_data(a_data), .a_valid(a_valid),
        .a_ready(a_ready2), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready2), .in_last(in_last),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .sat_en(sat_en), .uf_sat(uf_sat),
        .overflow(ovf2), .underflow(uf2));

    always #5 clk = ~clk;

    // Collect every handshaken result; out_ready only changes just after posedge.
    always @(negedge clk) begin
        if (!reset && ov0 && out_ready) begin
            res_t e;
            e.d0 = 64'(od0); e.d1 = 64'(od1); e.d2 = 64'(od2);
            e.o0 = ovf0; e.o1 = ovf1; e.o2 = ovf2;
            e.u0 = uf0;  e.u1 = uf1;  e.u2 = uf2;
            q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*12-1:0] rep_a(input logic [11:0] v);
        return {LANES{v}};
    endfunction
    function automatic logic [LANES*8-1:0] rep_b(input logic [7:0] v);
        return {LANES{v}};
    endfunction

    // Present one beat; handshake decided from readies at negedge, accepted on next posedge.
    task automatic send(input logic [LANES*12-1:0] a, input logic [LANES*8-1:0] b, input logic last);
        int n;
        a_data = a; b_data = b; in_last = last; a_valid = 1'b1; b_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (a_ready && b_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_res();
        int k;
        k = 0;
        while (q.size() == 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (q.size() == 0) begin
            chk("result_timeout", 64'd0, 64'd1);
            r = '{default: '0};
        end else begin
            r = q.pop_front();
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; sat_en = 1'b1; uf_sat = 1'b0; a_data = '0; b_data = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_out_data", 64'(od0), 64'd0);
        chk("rst_flags", 64'({ovf0, uf0}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("idle_a_ready", 64'(a_ready), 64'd0);
        b_valid = 1'b1;
        #1;
        chk("a_ready_follows_b_valid", 64'({a_ready, b_ready}), 64'b10);
        b_valid = 1'b0;

        // 1: three beats of 4.0 -> 12.0; latency 4 edges from accept
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_not_early", 64'(ov0), 64'd0);
        @(posedge clk); #1;
        chk("t1_valid_t4", 64'(ov0), 64'd1);
        get_res();
        chk("t1_data", r.d0, 64'h3_0000_0000);
        chk("t1_flags", 64'({r.o0, r.u0}), 64'd0);
        chk("t3_sat_data", r.d1, 64'h7F);
        chk("t3_sat_ovf", 64'(r.o1), 64'd1);
        chk("q15_4_12", r.d2, 64'hC0);
        chk("q15_4_flags", 64'({r.o2, r.u2}), 64'd0);

        // 3: wrap mode on the same packet
        sat_en = 1'b0;
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b1);
        get_res();
        chk("t3_wrap_data", r.d1, 64'hC0);
        chk("t3_wrap_ovf", 64'(r.o1), 64'd1);
        chk("t3_wrap_full", r.d0, 64'h3_0000_0000);
        sat_en = 1'b1;

        // 2: single-beat negative packet, -1.0 * 0.5 * 4 = -2.0
        send(rep_a(12'hF00), rep_b(8'h10), 1'b1);
        get_res();
        chk("t2_data", r.d0, 64'h1FFF_8000_0000);
        chk("t2_flags", 64'({r.o0, r.u0}), 64'd0);
        chk("t2_q4_4", r.d1, 64'hE0);
        chk("t2_q15_4", r.d2, 64'h7FFE0);

        // 4: tiny lane0 product 1/256 underflows in 4 fraction bits
        send({36'd0, 12'h001}, {24'd0, 8'h20}, 1'b1);
        get_res();
        chk("t4_uf0_data", r.d2, 64'd0);
        chk("t4_uf0_flag", 64'({r.o2, r.u2}), 64'b01);
        chk("t4_uf0_q4_4", 64'({r.d1[7:0], r.u1}), {55'd0, 9'b0_0000_0001});
        chk("t4_full_exact", r.d0, 64'h40_0000);
        chk("t4_full_flags", 64'({r.o0, r.u0}), 64'd0);
        uf_sat = 1'b1;
        send({36'd0, 12'h001}, {24'd0, 8'h20}, 1'b1);
        get_res();
        chk("t4_uf1_data", r.d2, 64'd1);
        chk("t4_uf1_flag", 64'({r.o2, r.u2}), 64'b01);
        send({36'd0, 12'hFFF}, {24'd0, 8'h20}, 1'b1);
        get_res();
        chk("t4_uf1_neg_data", r.d2, 64'h7FFFF);
        chk("t4_uf1_neg_flag", 64'({r.o2, r.u2}), 64'b01);
        // exactly half an output LSB rounds up, so no underflow
        send({36'd0, 12'h008}, {24'd0, 8'h20}, 1'b1);
        get_res();
        chk("round_half_up", r.d2, 64'd1);
        chk("round_half_up_flag", 64'({r.o2, r.u2}), 64'd0);
        chk("round_full", r.d0, 64'h200_0000);
        uf_sat = 1'b0;

        // 5: 2.0, 5.0, then 3-beat 12.0 back to back; stall 6 cycles on the first result
        fork
            begin
                send(rep_a(12'h080), rep_b(8'h20), 1'b1);
                send(rep_a(12'h140), rep_b(8'h20), 1'b1);
                send(rep_a(12'h100), rep_b(8'h20), 1'b0);
                send(rep_a(12'h100), rep_b(8'h20), 1'b0);
                send(rep_a(12'h100), rep_b(8'h20), 1'b1);
            end
            begin
                logic [44:0] held;
                int k;
                k = 0;
                while (!ov0 && k < 100) begin
                    @(posedge clk); #1;
                    k++;
                end
                out_ready = 1'b0;
                held = od0;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    chk("t5_readies_low", 64'({a_ready, b_ready}), 64'd0);
                    chk("t5_data_held", 64'(od0), 64'h8000_0000);
                    chk("t5_held_stable", 64'(od0), 64'(held));
                end
                out_ready = 1'b1;
            end
        join
        get_res();
        chk("t5_res0", r.d0, 64'h8000_0000);
        get_res();
        chk("t5_res1", r.d0, 64'h1_4000_0000);
        get_res();
        chk("t5_res2", r.d0, 64'h3_0000_0000);

        // 6: reset in the middle of a packet while a result is held
        out_ready = 1'b0;
        send(rep_a(12'h080), rep_b(8'h20), 1'b1);
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        @(posedge clk); #1;
        chk("t6_held_valid", 64'(ov0), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(ov0), 64'd0);
        chk("t6_rst_data", 64'(od0), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        out_ready = 1'b1;
        send(rep_a(12'h100), rep_b(8'h20), 1'b0);
        send(rep_a(12'h100), rep_b(8'h20), 1'b1);
        get_res();
        chk("t6_fresh_sum", r.d0, 64'h2_0000_0000);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_no_extra", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
